// File: rtl/phy_tx_sched_pkg.sv
// Shared definitions for the two-requester PHY transmit scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package phy_tx_sched_pkg;

  localparam int DATA_W        = 32;
  localparam int DEPTH_DEF     = 4;
  localparam int BURST_MAX_DEF = 4;

  // Arbiter state doubles as "current owner" of the phy_tx word slot.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERV0 = 2'd1,
    SERV1 = 2'd2
  } sched_state_e;

endpackage

// File: rtl/sched_fifo.sv
// Per-requester word FIFO with registered full/empty and sticky overflow flag.
// Latency: a pushed word is visible at data_o (head) after the push edge.
// Backpressure: push while full is dropped and sets ovf_o until reset; pop while empty is ignored.
module sched_fifo
  import phy_tx_sched_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk_f,
  input  logic              reset_L,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     cnt_q;
  logic              ovf_q;
  logic              push_ok;
  logic              pop_ok;

  // Full is taken from the registered count, so a same-cycle pop never makes room.
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign ovf_o   = ovf_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
      if (push_i && full_o) ovf_q <= 1'b1;
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk_f) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/phy_tx_sched.sv
// Arbitrates two requester FIFOs onto one phy_tx word stream with bounded bursts.
// Latency: word pushed into an empty FIFO with the scheduler idle appears on entrada two edges later (push edge + pop edge).
// Backpressure: tx_enable=0 stalls pops and freezes arbitration; FIFOs drop and flag pushes while full.
module phy_tx_sched
  import phy_tx_sched_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic        clk_f,
  input  logic        reset_L,
  input  logic        tx_enable,
  input  logic [31:0] data_in0,
  input  logic [31:0] data_in1,
  input  logic        push0,
  input  logic        push1,
  output logic        full0,
  output logic        full1,
  output logic        ovf0,
  output logic        ovf1,
  output logic [31:0] entrada,
  output logic        valid,
  output logic        selector_tx
);

  localparam int             BW   = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0]  BMAX = BW'(BURST_MAX);

  logic         empty0, empty1;
  logic [31:0]  head0, head1;
  logic         pop0, pop1;
  logic         do_pop, pop_sel;
  logic         own_empty, oth_empty, own_is1;

  sched_state_e state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic         last_q, last_d;
  logic [31:0]  entrada_q;
  logic         valid_q;
  logic         sel_q;

  sched_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk_f   (clk_f),
    .reset_L (reset_L),
    .push_i  (push0),
    .data_i  (data_in0),
    .pop_i   (pop0),
    .data_o  (head0),
    .full_o  (full0),
    .empty_o (empty0),
    .ovf_o   (ovf0)
  );

  sched_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk_f   (clk_f),
    .reset_L (reset_L),
    .push_i  (push1),
    .data_i  (data_in1),
    .pop_i   (pop1),
    .data_o  (head1),
    .full_o  (full1),
    .empty_o (empty1),
    .ovf_o   (ovf1)
  );

  assign own_is1   = (state_q == SERV1);
  assign own_empty = own_is1 ? empty1 : empty0;
  assign oth_empty = own_is1 ? empty0 : empty1;
  assign pop0      = do_pop & ~pop_sel;
  assign pop1      = do_pop &  pop_sel;

  // Grant decision from registered occupancy: who pops this cycle and where the FSM goes.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    last_d  = last_q;
    do_pop  = 1'b0;
    pop_sel = 1'b0;
    if (tx_enable) begin
      case (state_q)
        IDLE: begin
          // Both waiting: the requester that did not finish last goes first.
          if (!empty0 && (empty1 || last_q)) begin
            do_pop  = 1'b1;
            pop_sel = 1'b0;
            state_d = SERV0;
            burst_d = BW'(1);
          end else if (!empty1) begin
            do_pop  = 1'b1;
            pop_sel = 1'b1;
            state_d = SERV1;
            burst_d = BW'(1);
          end
        end
        SERV0, SERV1: begin
          if (!own_empty && (burst_q < BMAX || oth_empty)) begin
            // Burst limit only matters when the other side is waiting; otherwise restart the count.
            do_pop  = 1'b1;
            pop_sel = own_is1;
            burst_d = (burst_q == BMAX) ? BW'(1) : burst_q + 1'b1;
          end else if (!oth_empty) begin
            do_pop  = 1'b1;
            pop_sel = ~own_is1;
            state_d = own_is1 ? SERV0 : SERV1;
            burst_d = BW'(1);
          end else begin
            state_d = IDLE;
            burst_d = '0;
            last_d  = own_is1;
          end
        end
        default: begin
          state_d = IDLE;
          burst_d = '0;
        end
      endcase
    end
  end

  // Arbiter state and the registered word presented to phy_tx.
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= IDLE;
      burst_q   <= '0;
      last_q    <= 1'b1;
      entrada_q <= 32'h0;
      valid_q   <= 1'b0;
      sel_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      last_q  <= last_d;
      valid_q <= do_pop;
      if (do_pop) begin
        entrada_q <= pop_sel ? head1 : head0;
        sel_q     <= pop_sel;
      end
    end
  end

  assign entrada     = entrada_q;
  assign valid       = valid_q;
  assign selector_tx = sel_q;

endmodule
